// File: rtl/imm_gen_pkg.sv
// Shared opcode and format encodings for the pipelined RV32I/RV64I immediate generator.
package imm_gen_pkg;

  localparam int FMT_W = 3;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [FMT_W-1:0] FMT_R       = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I       = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S       = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B       = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U       = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J       = 3'd5;
  localparam logic [FMT_W-1:0] FMT_SHAMT   = 3'd6;
  localparam logic [FMT_W-1:0] FMT_ILLEGAL = 3'd7;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode by full opcode, sign-extended to XLEN; no state, no handshake.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      i_instr,
  output logic [XLEN-1:0]  o_imm,
  output logic [FMT_W-1:0] o_fmt,
  output logic             o_illegal
);

  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_shamt;
  logic            w_is_shift;
  logic            w_rv64;

  assign w_rv64     = (XLEN == 64);
  assign w_is_shift = (i_instr[14:12] == 3'b001) || (i_instr[14:12] == 3'b101);

  assign w_imm_i = XLEN'($signed(i_instr[31:20]));
  assign w_imm_s = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_instr[31:12], 12'h000}));
  assign w_imm_j = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
  // shamt widens by one bit on RV64; funct7 is never part of the value
  assign w_shamt = w_rv64 ? XLEN'(i_instr[25:20]) : XLEN'(i_instr[24:20]);

  always_comb begin
    o_imm     = '0;
    o_fmt     = FMT_ILLEGAL;
    o_illegal = 1'b1;
    case (i_instr[6:0])
      OPC_OP_IMM: begin
        o_illegal = 1'b0;
        o_fmt     = w_is_shift ? FMT_SHAMT : FMT_I;
        o_imm     = w_is_shift ? w_shamt : w_imm_i;
      end
      OPC_OP_IMM_32: begin
        if (w_rv64) begin
          o_illegal = 1'b0;
          o_fmt     = w_is_shift ? FMT_SHAMT : FMT_I;
          o_imm     = w_is_shift ? w_shamt : w_imm_i;
        end
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        o_illegal = 1'b0;
        o_fmt     = FMT_I;
        o_imm     = w_imm_i;
      end
      OPC_STORE: begin
        o_illegal = 1'b0;
        o_fmt     = FMT_S;
        o_imm     = w_imm_s;
      end
      OPC_BRANCH: begin
        o_illegal = 1'b0;
        o_fmt     = FMT_B;
        o_imm     = w_imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        o_illegal = 1'b0;
        o_fmt     = FMT_U;
        o_imm     = w_imm_u;
      end
      OPC_JAL: begin
        o_illegal = 1'b0;
        o_fmt     = FMT_J;
        o_imm     = w_imm_j;
      end
      OPC_OP: begin
        o_illegal = 1'b0;
        o_fmt     = FMT_R;
      end
      OPC_OP_32: begin
        if (w_rv64) begin
          o_illegal = 1'b0;
          o_fmt     = FMT_R;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decoded immediate behind a 1-cycle main register plus one-entry skid; in_ready_o is registered.
// Optional IMM_GEN_PERF_CNT_EN adds a saturating count of accepted illegal instructions.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [FMT_W-1:0] fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
`ifdef IMM_GEN_PERF_CNT_EN
  ,
  output logic [31:0]      illegal_cnt_o
`endif
);

  logic [XLEN-1:0]  w_imm;
  logic [FMT_W-1:0] w_fmt;
  logic             w_ill;
  logic             w_accept;

  logic             r_m_vld;
  logic [XLEN-1:0]  r_m_imm;
  logic [FMT_W-1:0] r_m_fmt;
  logic             r_m_ill;
  logic [TAG_W-1:0] r_m_tag;

  logic             r_s_vld;
  logic [XLEN-1:0]  r_s_imm;
  logic [FMT_W-1:0] r_s_fmt;
  logic             r_s_ill;
  logic [TAG_W-1:0] r_s_tag;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_instr   (instr_i),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_ill)
  );

  assign w_accept = in_valid_i & !r_s_vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_m_vld <= 1'b0;
      r_m_imm <= '0;
      r_m_fmt <= '0;
      r_m_ill <= 1'b0;
      r_m_tag <= '0;
      r_s_vld <= 1'b0;
      r_s_imm <= '0;
      r_s_fmt <= '0;
      r_s_ill <= 1'b0;
      r_s_tag <= '0;
    end else if (flush_i) begin
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else if (!r_m_vld || out_ready_i) begin
      // main is free this edge: the older skid entry has priority over new input
      if (r_s_vld) begin
        r_m_vld <= 1'b1;
        r_m_imm <= r_s_imm;
        r_m_fmt <= r_s_fmt;
        r_m_ill <= r_s_ill;
        r_m_tag <= r_s_tag;
        r_s_vld <= 1'b0;
      end else if (w_accept) begin
        r_m_vld <= 1'b1;
        r_m_imm <= w_imm;
        r_m_fmt <= w_fmt;
        r_m_ill <= w_ill;
        r_m_tag <= tag_i;
      end else begin
        r_m_vld <= 1'b0;
      end
    end else if (w_accept) begin
      r_s_vld <= 1'b1;
      r_s_imm <= w_imm;
      r_s_fmt <= w_fmt;
      r_s_ill <= w_ill;
      r_s_tag <= tag_i;
    end
  end

  assign in_ready_o  = !r_s_vld;
  assign out_valid_o = r_m_vld;
  assign imm_o       = r_m_imm;
  assign fmt_o       = r_m_fmt;
  assign illegal_o   = r_m_ill;
  assign tag_o       = r_m_tag;

`ifdef IMM_GEN_PERF_CNT_EN
  logic [31:0] r_ill_cnt;

  // counts at the handshake, so an entry later lost to flush is still counted
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ill_cnt <= '0;
    end else if (w_accept && w_ill && (r_ill_cnt != 32'hFFFF_FFFF)) begin
      r_ill_cnt <= r_ill_cnt + 32'd1;
    end
  end

  assign illegal_cnt_o = r_ill_cnt;
`else
  // build without the illegal-instruction counter
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] instr_i = '0;
  logic [31:0] tag_i = '0;
  logic        out_ready_i = 1'b0;

  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
`ifdef IMM_GEN_PERF_CNT_EN
  logic [31:0] cnt32, cnt64;
`endif

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(rdy32), .instr_i(instr_i), .tag_i(tag_i), .out_valid_o(vld32),
    .out_ready_i(out_ready_i), .imm_o(imm32), .fmt_o(fmt32), .illegal_o(ill32),
    .tag_o(tag32)
`ifdef IMM_GEN_PERF_CNT_EN
    , .illegal_cnt_o(cnt32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i),
    .in_ready_o(rdy64), .instr_i(instr_i), .tag_i(tag_i), .out_valid_o(vld64),
    .out_ready_i(out_ready_i), .imm_o(imm64), .fmt_o(fmt64), .illegal_o(ill64),
    .tag_o(tag64)
`ifdef IMM_GEN_PERF_CNT_EN
    , .illegal_cnt_o(cnt64)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } dec_t;

  // Reference decode from the ISA field layout, using shifts/ORs on a 64-bit value.
  function automatic dec_t model(input logic [31:0] ins, input int xl);
    dec_t        d;
    logic [63:0] sg;
    logic [6:0]  op;
    bit          sh;
    bit          opimm;
    sg = ins[31] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
    op = ins[6:0];
    sh = (ins[14:12] == 3'd1) || (ins[14:12] == 3'd5);
    opimm = (op == 7'h13) || (op == 7'h1B && xl == 64);
    d.imm = 64'h0;
    d.fmt = 3'd0;
    d.ill = 1'b0;
    if (opimm && sh) begin
      d.fmt = 3'd6;
      d.imm = (xl == 64) ? 64'(ins[25:20]) : 64'(ins[24:20]);
    end else if (opimm || op == 7'h03 || op == 7'h67 || op == 7'h73) begin
      d.fmt = 3'd1;
      d.imm = (sg << 12) | 64'(ins[31:20]);
    end else if (op == 7'h23) begin
      d.fmt = 3'd2;
      d.imm = (sg << 12) | (64'(ins[31:25]) << 5) | 64'(ins[11:7]);
    end else if (op == 7'h63) begin
      d.fmt = 3'd3;
      d.imm = (sg << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
    end else if (op == 7'h37 || op == 7'h17) begin
      d.fmt = 3'd4;
      d.imm = (sg << 32) | (64'(ins[31:12]) << 12);
    end else if (op == 7'h6F) begin
      d.fmt = 3'd5;
      d.imm = (sg << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
    end else if (op == 7'h33 || (op == 7'h3B && xl == 64)) begin
      d.fmt = 3'd0;
    end else begin
      d.fmt = 3'd7;
      d.ill = 1'b1;
    end
    if (xl == 32) d.imm[63:32] = 32'h0;
    return d;
  endfunction

  typedef struct {
    logic [31:0] ins;
    logic [31:0] tag;
  } ent_t;

  ent_t        q[$];
  bit          stall = 0;
  logic [99:0] prev32, prev64;
  logic [31:0] mcnt = 0;

  always @(negedge clk) begin
    dec_t e32, e64;
    if (rst_i) begin
      q.delete();
      stall = 0;
      mcnt  = 0;
    end else begin
      chk("out_valid32", 128'(vld32), 128'(q.size() != 0));
      chk("out_valid64", 128'(vld64), 128'(q.size() != 0));
      chk("in_ready", 128'(rdy32), 128'(q.size() < 2));
`ifdef IMM_GEN_PERF_CNT_EN
      chk("illegal_cnt", 128'(cnt32), 128'(mcnt));
`endif
      if (stall) begin
        chk("stable32", 128'({32'h0, imm32, fmt32, ill32, tag32}), 128'(prev32));
        chk("stable64", 128'({imm64, fmt64, ill64, tag64}), 128'(prev64));
      end
      if (vld32 && out_ready_i && q.size() > 0) begin
        e32 = model(q[0].ins, 32);
        e64 = model(q[0].ins, 64);
        chk("result32", 128'({32'h0, imm32, fmt32, ill32, tag32}),
            128'({e32.imm, e32.fmt, e32.ill, q[0].tag}));
        chk("result64", 128'({imm64, fmt64, ill64, tag64}),
            128'({e64.imm, e64.fmt, e64.ill, q[0].tag}));
        void'(q.pop_front());
      end
      if (in_valid_i && rdy32) begin
        e32 = model(instr_i, 32);
        if (e32.ill && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
        if (!flush_i) q.push_back('{ins: instr_i, tag: tag_i});
      end
      if (flush_i) q.delete();
      stall  = vld32 && !out_ready_i && !flush_i;
      prev32 = {32'h0, imm32, fmt32, ill32, tag32};
      prev64 = {imm64, fmt64, ill64, tag64};
    end
  end

  logic [31:0] t_ins [12] = '{32'hFFF00093, 32'h4030D093, 32'hFE20AE23, 32'hFE000CE3,
                              32'h123452B7, 32'h001000EF, 32'h0000007F, 32'h00B50533,
                              32'h4230D093, 32'h800002B7, 32'h0010809B, 32'h00B5053B};
  logic [31:0] t_e32 [12] = '{32'hFFFFFFFF, 32'h3, 32'hFFFFFFFC, 32'hFFFFFFF8,
                              32'h12345000, 32'h800, 32'h0, 32'h0,
                              32'h3, 32'h80000000, 32'h0, 32'h0};
  logic [2:0]  t_f32 [12] = '{3'd1, 3'd6, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd6, 3'd4, 3'd7, 3'd7};
  logic        t_l32 [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1};
  logic [63:0] t_e64 [12] = '{64'hFFFFFFFFFFFFFFFF, 64'h3, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                              64'h12345000, 64'h800, 64'h0, 64'h0,
                              64'h23, 64'hFFFFFFFF80000000, 64'h1, 64'h0};
  logic [2:0]  t_f64 [12] = '{3'd1, 3'd6, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0, 3'd6, 3'd4, 3'd1, 3'd0};
  logic        t_l64 [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] tg);
    in_valid_i = v;
    instr_i    = ins;
    tag_i      = tg;
  endtask

  initial begin
    dec_t m;
    repeat (2) cyc();
    chk("reset_outputs", 128'({vld32, imm32, fmt32, ill32, tag32}), 128'(0));
    chk("reset_outputs64", 128'({vld64, imm64, fmt64, ill64, tag64}), 128'(0));
    chk("reset_in_ready", 128'(rdy32), 128'(1));
    rst_i = 1'b0;
    cyc();

    out_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      m = model(t_ins[i], 32);
      chk("model32", 128'({m.imm, m.fmt, m.ill}), 128'({32'h0, t_e32[i], t_f32[i], t_l32[i]}));
      m = model(t_ins[i], 64);
      chk("model64", 128'({m.imm, m.fmt, m.ill}), 128'({t_e64[i], t_f64[i], t_l64[i]}));
      drive(1'b1, t_ins[i], 32'(100 + i));
      cyc();
      chk("lat1_valid", 128'({vld32, vld64}), 128'(2'b11));
      chk("dec32", 128'({imm32, fmt32, ill32}), 128'({t_e32[i], t_f32[i], t_l32[i]}));
      chk("dec64", 128'({imm64, fmt64, ill64}), 128'({t_e64[i], t_f64[i], t_l64[i]}));
      chk("tag", 128'(tag32), 128'(100 + i));
    end
    drive(1'b0, 32'h0, 32'h0);
    cyc();

    // backpressure: third offer must see in_ready low, then drain in order
    out_ready_i = 1'b0;
    drive(1'b1, 32'h00108093, 32'd1);
    cyc();
    chk("bp_ready1", 128'(rdy32), 128'(1));
    drive(1'b1, 32'h00208093, 32'd2);
    cyc();
    chk("bp_ready2", 128'(rdy32), 128'(0));
    chk("bp_tag_hold", 128'(tag32), 128'(1));
    drive(1'b1, 32'h00308093, 32'd3);
    cyc();
    chk("bp_ready3", 128'(rdy32), 128'(0));
    chk("bp_imm_hold", 128'({vld32, imm32, tag32}), 128'({1'b1, 32'h1, 32'd1}));
    out_ready_i = 1'b1;
    cyc();
    chk("bp_order2", 128'({vld32, tag32, imm32}), 128'({1'b1, 32'd2, 32'h2}));
    chk("bp_ready_back", 128'(rdy32), 128'(1));
    cyc();
    chk("bp_order3", 128'({vld32, tag32, imm32}), 128'({1'b1, 32'd3, 32'h3}));
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    chk("bp_drained", 128'(vld32), 128'(0));

    // flush with both registers full and a new input offered
    out_ready_i = 1'b0;
    drive(1'b1, 32'h00A00093, 32'd10);
    cyc();
    drive(1'b1, 32'h00B00093, 32'd11);
    cyc();
    drive(1'b1, 32'h00C00093, 32'd12);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    chk("flush_valid", 128'({vld32, vld64}), 128'(0));
    chk("flush_ready", 128'(rdy32), 128'(1));
    drive(1'b0, 32'h0, 32'h0);
    out_ready_i = 1'b1;
    cyc();
    chk("flush_dropped", 128'(vld32), 128'(0));

    // asynchronous reset mid-cycle with data held
    out_ready_i = 1'b0;
    drive(1'b1, 32'hFFF00093, 32'd20);
    cyc();
    drive(1'b1, 32'h123452B7, 32'd21);
    cyc();
    drive(1'b0, 32'h0, 32'h0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_outputs", 128'({vld32, imm32, fmt32, ill32, tag32}), 128'(0));
    chk("arst_ready", 128'(rdy32), 128'(1));
    cyc();
    rst_i = 1'b0;
    cyc();

`ifdef IMM_GEN_PERF_CNT_EN
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i < 5) ? 32'h0000007F : 32'h00108093, 32'(i));
      cyc();
    end
    drive(1'b0, 32'h0, 32'h0);
    cyc();
    chk("perf_cnt5", 128'(cnt32), 128'(5));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
